// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter for one UART TX FIFO write port; one idle cycle arbitrates, then bytes pass combinationally.
// Backpressure: fifo_full gates req_ready/fifo_wr_en of the owner; the grant is held until last or the length guard.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int MAX_PKT_BYTES = 64
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]         fifo_din,
  output logic                         fifo_wr_en,
  input  logic                         fifo_full,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         truncated
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_PKT_BYTES > 0) ? $clog2(MAX_PKT_BYTES + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT_BYTES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [PTR_W-1:0]     r_gidx, w_gidx_nxt;
  logic [PTR_W-1:0]     r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0]     r_byte_cnt, w_cnt_nxt, w_cnt_inc;
  logic                 r_trunc, w_trunc_nxt;
  logic                 w_valid_g, w_last_g, w_accept, w_guard_hit, w_found;
  logic [PTR_W-1:0]     w_cand, w_win;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // r_grant is non-zero only in SEND, so an all-zero grant forces din/valid/last to 0.
  always_comb begin
    fifo_din  = '0;
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        fifo_din  = req_data[i*DATA_BITS +: DATA_BITS];
        w_valid_g = req_valid[i];
        w_last_g  = req_last[i];
      end
    end
  end

  assign req_ready   = r_grant & {NUM_REQ{~fifo_full}};
  assign fifo_wr_en  = w_valid_g & ~fifo_full;
  assign w_accept    = fifo_wr_en;
  assign w_cnt_inc   = r_byte_cnt + 1'b1;
  assign w_guard_hit = (MAX_PKT_BYTES > 0) && (w_cnt_inc == MAX_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_byte_cnt;
    w_trunc_nxt = 1'b0;
    w_found     = 1'b0;
    w_win       = r_rr_ptr;
    w_cand      = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!w_found && req_valid[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
          end
          w_cand = wrap_inc(w_cand);
        end
        if (w_found) begin
          w_state_nxt = S_SEND;
          w_grant_nxt = NUM_REQ'(1) << w_win;
          w_gidx_nxt  = w_win;
          w_cnt_nxt   = '0;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          w_cnt_nxt = w_cnt_inc;
          // A last byte that also fills the guard is an ordinary packet end.
          if (w_last_g || w_guard_hit) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_rr_nxt    = wrap_inc(r_gidx);
            w_trunc_nxt = ~w_last_g;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_trunc    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_byte_cnt <= w_cnt_nxt;
      r_trunc    <= w_trunc_nxt;
    end
  end

  assign grant     = r_grant;
  assign busy      = (r_state == S_SEND);
  assign truncated = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: per-requester byte queues plus a packet-level arbitration model.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [DW-1:0]   fifo_din;
  logic            fifo_wr_en, fifo_full, busy, truncated;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .MAX_PKT_BYTES(MAXB)) dut (
    .clk(clk), .rstn(rstn), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .grant(grant),
    .busy(busy), .truncated(truncated));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] src [N][$];
  logic [7:0] sb  [N][$];
  bit         full_q[$];
  int         go_pct = 100;
  int         full_pct = 0;
  logic [N-1:0] acc = '0;

  int   m_own = -1;
  int   m_rr = 0;
  int   m_cnt = 0;
  bit   m_tr = 1'b0;
  bit   n_tr;
  logic [N-1:0] e_grant, e_rdy, prev_grant = '0;
  bit   e_wr;

  logic [7:0] wr_log[$];
  int         own_log[$];
  int         trunc_cnt = 0;
  logic [7:0] exp_wr[$];
  int         exp_own[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic add_pkt(input int r, input int len, input logic [7:0] base);
    logic [7:0] b;
    logic       lst;
    for (int j = 0; j < len; j++) begin
      b   = base + 8'(j);
      lst = (j == len - 1);
      src[r].push_back({lst, b});
      sb[r].push_back(b);
    end
  endtask

  task automatic exp_seq(input logic [7:0] base, input int len);
    for (int j = 0; j < len; j++) exp_wr.push_back(base + 8'(j));
  endtask

  function automatic int sb_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += sb[i].size();
    return t;
  endfunction

  function automatic bit idle_now();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b0;
    return (full_q.size() == 0) && !busy && (m_own < 0);
  endfunction

  task automatic clear_logs();
    wr_log.delete(); own_log.delete(); exp_wr.delete(); exp_own.delete();
    trunc_cnt = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk); #2;
      done = idle_now();
      n++;
      if (!done && n >= budget) begin
        checks++; errors++;
        $display("FAIL %s_timeout got=%0d cycles exp=idle", name, n);
        for (int i = 0; i < N; i++) begin src[i].delete(); sb[i].delete(); end
        full_q.delete();
        done = 1'b1;
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2 rstn = 1'b0;
    @(posedge clk); #2 rstn = 1'b1;
    clear_logs();
  endtask

  task automatic check_phase(input string name, input int exp_tr);
    chk({name, "_wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int j = 0; j < exp_wr.size() && j < wr_log.size(); j++)
      chk($sformatf("%s_wr%0d", name, j), 32'(wr_log[j]), 32'(exp_wr[j]));
    chk({name, "_grant_count"}, 32'(own_log.size()), 32'(exp_own.size()));
    for (int j = 0; j < exp_own.size() && j < own_log.size(); j++)
      chk($sformatf("%s_owner%0d", name, j), 32'(own_log[j]), 32'(exp_own[j]));
    chk({name, "_truncated"}, 32'(trunc_cnt), 32'(exp_tr));
    chk({name, "_leftover"}, 32'(sb_total()), 32'd0);
  endtask

  // Driver: holds a presented byte until accepted, then moves to the next one.
  always begin
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
      if (src[i].size() == 0) begin
        req_valid[i] = 1'b0;
      end else begin
        if (!(req_valid[i] && !acc[i])) req_valid[i] = ($urandom_range(99) < go_pct);
        req_data[i*DW +: DW] = src[i][0][7:0];
        req_last[i]          = src[i][0][8];
      end
    end
    if (full_q.size() > 0) fifo_full = full_q.pop_front();
    else                   fifo_full = ($urandom_range(99) < full_pct);
  end

  // Monitor + reference model: owner/rr/count tracked as plain integers.
  always begin
    @(negedge clk); #1;
    if (!rstn) begin m_own = -1; m_rr = 0; m_cnt = 0; m_tr = 1'b0; end
    e_grant = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    e_rdy   = fifo_full ? 4'b0000 : e_grant;
    e_wr    = ((e_grant & req_valid) != 4'b0000) && !fifo_full;
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy", 32'(busy), 32'(m_own >= 0));
    chk("truncated", 32'(truncated), 32'(m_tr));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    if (e_wr) begin
      if (sb[m_own].size() == 0) begin
        checks++; errors++;
        $display("FAIL din_unexpected got=0x%0h exp=none", fifo_din);
      end else begin
        chk($sformatf("din_req%0d", m_own), 32'(fifo_din), 32'(sb[m_own].pop_front()));
      end
    end else if (m_own < 0) begin
      chk("din_idle", 32'(fifo_din), 32'd0);
    end
    if (fifo_wr_en) wr_log.push_back(fifo_din);
    if (grant != 0 && prev_grant == 0)
      for (int i = 0; i < N; i++) if (grant[i]) own_log.push_back(i);
    prev_grant = grant;
    if (truncated) trunc_cnt++;
    acc = req_valid & req_ready;
    if (rstn) begin
      n_tr = 1'b0;
      if (m_own >= 0) begin
        if (e_wr) begin
          m_cnt++;
          if (req_last[m_own] || m_cnt == MAXB) begin
            n_tr  = !req_last[m_own];
            m_rr  = (m_own + 1) % N;
            m_own = -1;
          end
        end
      end else begin
        for (int k = 0; k < N; k++)
          if (m_own < 0 && req_valid[(m_rr + k) % N]) begin
            m_own = (m_rr + k) % N;
            m_cnt = 0;
          end
      end
      m_tr = n_tr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int len;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_truncated", 32'(truncated), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    rstn = 1'b1;
    clear_logs();

    // Single requester, then probe that rr moved past requester 1.
    add_pkt(1, 3, 8'h41);
    @(posedge clk); #2;
    chk("single_grant_arb_cycle", 32'(grant), 32'd0);
    @(posedge clk); #2;
    chk("single_grant_next_cycle", 32'(grant), 32'b0010);
    wait_idle("single", 100);
    add_pkt(0, 1, 8'h90);
    add_pkt(2, 1, 8'hA0);
    wait_idle("rr_probe", 100);
    exp_seq(8'h41, 3); exp_seq(8'hA0, 1); exp_seq(8'h90, 1);
    exp_own = '{1, 2, 0};
    check_phase("single", 0);

    // Fairness: everyone streams two 2-byte packets.
    reset_pulse();
    for (int q = 0; q < N; q++) begin
      add_pkt(q, 2, 8'(16 * (q + 1)));
      add_pkt(q, 2, 8'(16 * (q + 1) + 2));
    end
    wait_idle("fair", 200);
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < N; q++) begin
        exp_own.push_back(q);
        exp_seq(8'(16 * (q + 1) + 2 * p), 2);
      end
    check_phase("fair", 0);

    // Backpressure: full during packet cycles 2-4.
    reset_pulse();
    add_pkt(0, 4, 8'h10);
    full_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    wait_idle("bp", 100);
    exp_seq(8'h10, 4); exp_own = '{0};
    check_phase("bp", 0);

    // Length guard splits a 6-byte packet.
    reset_pulse();
    add_pkt(2, 6, 8'h20);
    wait_idle("guard", 100);
    exp_seq(8'h20, 6); exp_own = '{2, 2};
    check_phase("guard", 1);

    // Guard and last on the same byte.
    reset_pulse();
    add_pkt(1, 4, 8'h30);
    wait_idle("guard_last", 100);
    exp_seq(8'h30, 4); exp_own = '{1};
    check_phase("guard_last", 0);

    // Reset in the middle of a 5-byte packet.
    reset_pulse();
    add_pkt(0, 5, 8'h50);
    len = 0;
    while (sb[0].size() > 3 && len < 50) begin @(negedge clk); #2; len++; end
    chk("mid_rst_progress", 32'(sb[0].size()), 32'd3);
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("mid_rst_din", 32'(fifo_din), 32'd0);
    chk("mid_rst_remaining", 32'(src[0].size()), 32'd3);
    src[0].delete(); sb[0].delete();
    add_pkt(3, 1, 8'h70);
    @(posedge clk); #2 rstn = 1'b1;
    clear_logs();
    @(posedge clk); #2;
    chk("post_rst_grant3", 32'(grant), 32'b1000);
    wait_idle("post_rst", 100);
    exp_seq(8'h70, 1); exp_own = '{3};
    check_phase("post_rst", 0);

    // Random traffic with valid gaps and random backpressure.
    reset_pulse();
    go_pct = 70;
    full_pct = 25;
    for (int p = 0; p < 60; p++) begin
      r   = $urandom_range(N - 1);
      len = $urandom_range(7, 1);
      add_pkt(r, len, 8'($urandom));
    end
    wait_idle("random", 20000);
    chk("random_leftover", 32'(sb_total()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
